// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between IFU reads and LSU reads/writes, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin grant; the default build uses fixed LSU-over-IFU priority.
module mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [63:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_addr,
  input  logic [7:0]  lsu_wen,
  input  logic [63:0] lsu_wdata,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [63:0] lsu_rdata,
  output logic        mem_ena,
  output logic [7:0]  mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LATENCY - 1);
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          owner;
  logic [63:0]   addr_q;
  logic [7:0]    wen_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rdata_q;
  logic          ifu_fire;
  logic          lsu_fire;
  logic          issue;
  logic          owner_resp_ready;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // A side is ready when the other is not competing, or when it lost the previous tie.
  assign ifu_req_ready = (state == IDLE) & (~lsu_req_valid | (last_grant == OWN_LSU));
  assign lsu_req_ready = (state == IDLE) & (~ifu_req_valid | (last_grant == OWN_IFU));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_IFU;
    end else if (lsu_fire) begin
      last_grant <= OWN_LSU;
    end else if (ifu_fire) begin
      last_grant <= OWN_IFU;
    end
  end
`else
  assign ifu_req_ready = (state == IDLE) & ~lsu_req_valid;
  assign lsu_req_ready = (state == IDLE);
`endif

  assign ifu_fire = ifu_req_valid & ifu_req_ready;
  assign lsu_fire = lsu_req_valid & lsu_req_ready;

  // The single enable pulse lands in the last ACCESS cycle and is suppressed under reset.
  assign issue   = (state == ACCESS) && (cnt == LAST_CNT);
  assign mem_ena = issue & ~rst;

  assign mem_addr  = mem_ena ? addr_q  : 64'd0;
  assign mem_wen   = mem_ena ? wen_q   : 8'd0;
  assign mem_wdata = mem_ena ? wdata_q : 64'd0;

  assign owner_resp_ready = (owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

  assign ifu_resp_valid = (state == RESP) && (owner == OWN_IFU);
  assign lsu_resp_valid = (state == RESP) && (owner == OWN_LSU);
  assign ifu_rdata      = ifu_resp_valid ? rdata_q : 64'd0;
  assign lsu_rdata      = lsu_resp_valid ? rdata_q : 64'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ifu_fire || lsu_fire) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (issue) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (owner_resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writes capture zero so the LSU write acknowledgement always carries rdata=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      owner   <= OWN_IFU;
      addr_q  <= 64'd0;
      wen_q   <= 8'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_fire) begin
            cnt     <= '0;
            owner   <= OWN_LSU;
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wdata;
          end else if (ifu_fire) begin
            cnt     <= '0;
            owner   <= OWN_IFU;
            addr_q  <= ifu_addr;
            wen_q   <= 8'd0;
            wdata_q <= 64'd0;
          end
        end
        ACCESS: begin
          cnt <= cnt + CW'(1);
          if (issue) begin
            rdata_q <= (wen_q == 8'd0) ? mem_rdata : 64'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checks every cycle of the
// MEM_LATENCY=1 instance; a second MEM_LATENCY=4 instance covers latency and mid-access reset.
module tb_mem_arbiter;

  localparam int LAT = 1;
  localparam int BLAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wen;
  logic        mem_ena;
  logic [7:0]  mem_wen;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_rst;
  logic        b_ifu_req_ready, b_ifu_resp_valid;
  logic [63:0] b_ifu_rdata;
  logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_resp_valid;
  logic [63:0] b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
  logic [7:0]  b_lsu_wen;
  logic        b_mem_ena;
  logic [7:0]  b_mem_wen;
  logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [63:0] dmem [0:8191];
  logic [63:0] rmem [0:8191];
  logic [63:0] bmem [0:8191];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(BLAT)) dut4 (
    .clk(clk), .rst(b_rst),
    .ifu_req_valid(1'b0), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(64'd0),
    .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(1'b1), .ifu_rdata(b_ifu_rdata),
    .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(b_lsu_addr),
    .lsu_wen(b_lsu_wen), .lsu_wdata(b_lsu_wdata),
    .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(b_lsu_rdata),
    .mem_ena(b_mem_ena), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  assign mem_rdata   = dmem[mem_addr[15:3]];
  assign b_mem_rdata = bmem[b_mem_addr[15:3]];

  // Behavioural memories behind the two DUT memory ports.
  initial begin
    for (int i = 0; i < 8192; i++) begin
      dmem[i] = 64'd0;
      bmem[i] = 64'd0;
    end
    dmem[0]     = 64'hDEADBEEF00000013;
    bmem[0]     = 64'hCAFEF00D12345678;
    bmem[13'h80] = 64'h5555555555555555;
    forever begin
      @(posedge clk);
      if (mem_ena)   dmem[mem_addr[15:3]]   = merge(dmem[mem_addr[15:3]], mem_wdata, mem_wen);
      if (b_mem_ena) bmem[b_mem_addr[15:3]] = merge(bmem[b_mem_addr[15:3]], b_mem_wdata, b_mem_wen);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: busy/age track cycles since acceptance; age LAT is the memory cycle.
  bit          m_busy;
  bit          m_own_lsu;
  int          m_age;
  logic [63:0] m_addr, m_wdata, m_data;
  logic [7:0]  m_wen;
  logic        e_iready, e_lready, e_ena, e_ivalid, e_lvalid;
  logic [63:0] e_irdata, e_lrdata, e_addr, e_wdata;
  logic [7:0]  e_wen;

  initial begin
    for (int i = 0; i < 8192; i++) rmem[i] = 64'd0;
    rmem[0] = 64'hDEADBEEF00000013;
    m_busy = 0;
    m_age = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_iready = 0; e_lready = 0; e_ena = 0; e_ivalid = 0; e_lvalid = 0;
      e_irdata = 0; e_lrdata = 0; e_addr = 0; e_wdata = 0; e_wen = 0;
      if (!m_busy) begin
        e_iready = !lsu_req_valid;
        e_lready = 1;
      end else if (m_age <= LAT) begin
        if (m_age == LAT && !rst) begin
          e_ena = 1; e_addr = m_addr; e_wen = m_wen; e_wdata = m_wdata;
        end
      end else if (m_own_lsu) begin
        e_lvalid = 1; e_lrdata = m_data;
      end else begin
        e_ivalid = 1; e_irdata = m_data;
      end
      checkOutput("ifu_req_ready", ifu_req_ready, e_iready);
      checkOutput("lsu_req_ready", lsu_req_ready, e_lready);
      checkOutput("ifu_resp_valid", ifu_resp_valid, e_ivalid);
      checkOutput("ifu_rdata", ifu_rdata, e_irdata);
      checkOutput("lsu_resp_valid", lsu_resp_valid, e_lvalid);
      checkOutput("lsu_rdata", lsu_rdata, e_lrdata);
      checkOutput("mem_ena", mem_ena, e_ena);
      checkOutput("mem_addr", mem_addr, e_addr);
      checkOutput("mem_wen", mem_wen, e_wen);
      checkOutput("mem_wdata", mem_wdata, e_wdata);
      if (rst) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (lsu_req_valid) begin
          m_busy = 1; m_own_lsu = 1; m_age = 1;
          m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata;
        end else if (ifu_req_valid) begin
          m_busy = 1; m_own_lsu = 0; m_age = 1;
          m_addr = ifu_addr; m_wen = 0; m_wdata = 0;
        end
      end else if (m_age <= LAT) begin
        if (m_age == LAT) begin
          m_data = (m_wen == 0) ? rmem[m_addr[15:3]] : 64'd0;
          rmem[m_addr[15:3]] = merge(rmem[m_addr[15:3]], m_wdata, m_wen);
        end
        m_age++;
      end else if (m_own_lsu ? lsu_resp_ready : ifu_resp_ready) begin
        m_busy = 0;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [63:0] ia, input logic lv,
                               input logic [63:0] la, input logic [7:0] lw, input logic [63:0] lwd);
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd;
  endtask

  task automatic applyB(input logic lv, input logic [63:0] la, input logic [7:0] lw,
                        input logic [63:0] lwd);
    b_lsu_req_valid = lv; b_lsu_addr = la; b_lsu_wen = lw; b_lsu_wdata = lwd;
  endtask

  // Bounded wait for a response; ends on the negedge where it is seen (timeout counts as FAIL).
  task automatic waitResp(input bit lsu, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(lsu ? lsu_resp_valid : ifu_resp_valid) && n < budget) begin
      nextCycle();
      @(negedge clk);
      n++;
    end
    checkOutput(name, lsu ? lsu_resp_valid : ifu_resp_valid, 1'b1);
  endtask

  initial begin
    int ena_cnt, resp_seen, lsu_acc, ifu_acc, lsu_hs, ena_at, resp_at;
    logic [63:0] rd;
    rst = 1; b_rst = 1;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyB(0, 0, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 0; b_rst = 0;
    @(negedge clk);
    checkOutput("t1 ifu_req_ready", ifu_req_ready, 1);
    checkOutput("t1 lsu_req_ready", lsu_req_ready, 1);
    checkOutput("t1 resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    checkOutput("t1 mem_ena", mem_ena, 0);
    checkOutput("t1 mem_addr", mem_addr, 0);

    // simple IFU read
    nextCycle();
    applyStimulus(1, 64'h80000000, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2 accept", ifu_req_ready, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2 mem_ena", mem_ena, 1);
    checkOutput("t2 mem_wen", mem_wen, 0);
    checkOutput("t2 mem_addr", mem_addr, 64'h80000000);
    nextCycle();
    @(negedge clk);
    checkOutput("t2 resp_valid", ifu_resp_valid, 1);
    checkOutput("t2 rdata", ifu_rdata, 64'hDEADBEEF00000013);
    nextCycle();

    // LSU write then IFU read-back
    applyStimulus(0, 0, 1, 64'h80001000, 8'hFF, 64'h1122334455667788);
    @(negedge clk);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    ena_cnt = 0; resp_seen = 0; rd = 64'hX;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_ena) ena_cnt++;
      if (lsu_resp_valid) begin
        resp_seen++;
        rd = lsu_rdata;
      end
      nextCycle();
    end
    checkOutput("t3 ena pulses", 64'(ena_cnt), 1);
    checkOutput("t3 write resp", 64'(resp_seen), 1);
    checkOutput("t3 write rdata", rd, 0);
    applyStimulus(1, 64'h80001000, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    waitResp(0, 6, "t3 read wait");
    checkOutput("t3 readback", ifu_rdata, 64'h1122334455667788);
    nextCycle();

    // simultaneous requests: LSU first, IFU right after LSU response handshake
    applyStimulus(1, 64'h80001000, 1, 64'h80000000, 8'h00, 64'd0);
    lsu_acc = -1; ifu_acc = -1; lsu_hs = -1;
    for (int c = 0; c < 12 && ifu_acc < 0; c++) begin
      @(negedge clk);
      if (lsu_req_valid && lsu_req_ready) lsu_acc = c;
      if (ifu_req_valid && ifu_req_ready) ifu_acc = c;
      if (lsu_resp_valid && lsu_resp_ready) lsu_hs = c;
      nextCycle();
      if (lsu_acc == c) lsu_req_valid = 0;
      if (ifu_acc == c) ifu_req_valid = 0;
    end
    checkOutput("t4 lsu accept cycle", 64'(lsu_acc), 0);
    checkOutput("t4 lsu handshake cycle", 64'(lsu_hs), 2);
    checkOutput("t4 ifu accept cycle", 64'(ifu_acc), 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    waitResp(0, 6, "t4 ifu resp wait");
    checkOutput("t4 ifu rdata", ifu_rdata, 64'h1122334455667788);
    nextCycle();

    // response backpressure
    ifu_resp_ready = 0;
    applyStimulus(1, 64'h80000000, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    waitResp(0, 6, "t5 resp wait");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        nextCycle();
        @(negedge clk);
      end
      checkOutput("t5 hold valid", ifu_resp_valid, 1);
      checkOutput("t5 hold rdata", ifu_rdata, 64'hDEADBEEF00000013);
      checkOutput("t5 hold mem_ena", mem_ena, 0);
      checkOutput("t5 hold readys", {ifu_req_ready, lsu_req_ready}, 0);
    end
    nextCycle();
    ifu_resp_ready = 1;
    @(negedge clk);
    checkOutput("t5 release valid", ifu_resp_valid, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("t5 idle ifu_req_ready", ifu_req_ready, 1);
    checkOutput("t5 idle resp_valid", ifu_resp_valid, 0);
    nextCycle();

    // MEM_LATENCY=4: normal read timing
    applyB(1, 64'h80000000, 8'h00, 64'd0);
    ena_at = -1; resp_at = -1; rd = 64'hX;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b_mem_ena && ena_at < 0) ena_at = c;
      if (b_lsu_resp_valid && resp_at < 0) begin
        resp_at = c;
        rd = b_lsu_rdata;
      end
      nextCycle();
      if (c == 0) applyB(0, 0, 0, 0);
    end
    checkOutput("t6 lat4 ena cycle", 64'(ena_at), 4);
    checkOutput("t6 lat4 resp cycle", 64'(resp_at), 5);
    checkOutput("t6 lat4 rdata", rd, 64'hCAFEF00D12345678);

    // MEM_LATENCY=4: reset in second ACCESS cycle drops the write
    applyB(1, 64'h80000400, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
    @(negedge clk);
    checkOutput("t6 accept", b_lsu_req_ready, 1);
    nextCycle();
    applyB(0, 0, 0, 0);
    nextCycle();
    b_rst = 1;
    @(negedge clk);
    checkOutput("t6 ena under reset", b_mem_ena, 0);
    nextCycle();
    b_rst = 0;
    @(negedge clk);
    checkOutput("t6 idle readys", {b_ifu_req_ready, b_lsu_req_ready}, 2'b11);
    checkOutput("t6 no resp", b_lsu_resp_valid, 0);
    ena_cnt = 0; resp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      @(negedge clk);
      if (b_mem_ena) ena_cnt++;
      if (b_lsu_resp_valid) resp_seen++;
    end
    checkOutput("t6 later ena", 64'(ena_cnt), 0);
    checkOutput("t6 later resp", 64'(resp_seen), 0);
    checkOutput("t6 memory unchanged", bmem[13'h80], 64'h5555555555555555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
